// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM slave.
interface ahb_lite_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: register-array memory, programmable wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_lite_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_sram_slave_if.slave bus
);
    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned MEM_BYTES = DEPTH * BYTES;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [BYTES-1:0]      mask_q;
    logic                  write_q;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic                  accept_c;
    logic                  legal_c;
    logic                  load_c;
    logic [OFF_W-1:0]      size_mask_c;
    logic [BYTES-1:0]      lane_mask_c;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // HBURST is informational only; HTRANS[0] does not change the access.
    logic unused_c;
    assign unused_c = ^{bus.HBURST, bus.HTRANS[0]};

    assign accept_c = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // Legality and little-endian byte-lane decode of the address phase.
    always_comb begin
        size_mask_c = OFF_W'((32'd1 << bus.HSIZE) - 32'd1);
        legal_c     = (bus.HADDR < ADDR_WIDTH'(MEM_BYTES)) &&
                      (bus.HSIZE <= 3'(OFF_W)) &&
                      ((bus.HADDR[OFF_W-1:0] & size_mask_c) == '0);
        lane_mask_c = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            lane_mask_c[b] = ((b >> bus.HSIZE) ==
                              (32'(bus.HADDR[OFF_W-1:0]) >> bus.HSIZE));
        end
    end

    // Next-state: ready states (IDLE/DATA/ERR2) may accept a new transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    load_c = 1'b1;
                    if (!legal_c) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    // State, wait counter, captured address phase and registered responses.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            hresp_q     <= (state_d == ST_ERR1) || (state_d == ST_ERR2);
            if (load_c) begin
                idx_q   <= bus.HADDR[OFF_W +: IDX_W];
                mask_q  <= lane_mask_c;
                write_q <= bus.HWRITE & legal_c;
            end
        end
    end

    // Write commits at the edge that ends the write's DATA cycle.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state_q == ST_DATA) && write_q) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (mask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem[idx_q] : '0;

endmodule
